// File: rtl/clock_pkg.sv
// Shared clock/alarm definitions.
// Holds the time-field widths and typedefs reused by the timekeeper, alarm-set
// registers and alarm controller, plus the alarm FSM state encoding.
package clock_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    typedef logic [HOUR_W-1:0] hour_t;
    typedef logic [MIN_W-1:0]  min_t;
    typedef logic [SEC_W-1:0]  sec_t;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZING
    } alarm_state_t;

endpackage

// File: rtl/blink_gen.sv
// 1 Hz, 50% duty blink generator phase-locked to the seconds tick.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   sec_tick in  one-cycle pulse per second
//   blink    out registered square wave, high for the first CLK_HZ/2 cycles after a tick
module blink_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sec_tick,
    output logic blink
);

    localparam int unsigned BW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [BW-1:0] BCNT_MAX  = BW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BCNT_HALF = BW'(CLK_HZ / 2);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q;

    // Saturate so a missing tick leaves blink parked low instead of wrapping.
    always_comb begin
        bcnt_d = bcnt_q;
        if (sec_tick) begin
            bcnt_d = '0;
        end else if (bcnt_q != BCNT_MAX) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            // Decode the next count so blink rises the cycle after the tick.
            blink_q <= (bcnt_d < BCNT_HALF);
        end
    end

    assign blink = blink_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: compares current time to the programmed alarm time and runs
// the ring / snooze / dismiss state machine; also produces the 1 Hz blink.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   sec_tick                    one-cycle pulse per second
//   cur_hour/cur_min/cur_sec    current time
//   alm_hour/alm_min            programmed alarm time
//   alarm_en                    alarm-armed level
//   snooze, dismiss             one-cycle button pulses
//   blink                       1 Hz square wave
//   alarm                       high while ringing
module alarm_controller
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic              alarm_en,
    input  logic              snooze,
    input  logic              dismiss,
    output logic              blink,
    output logic              alarm
);

    localparam int unsigned RW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int unsigned SW = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;
    localparam int unsigned UW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [RW-1:0] RING_LAST  = RW'(RING_TIMEOUT_S - 1);
    localparam logic [SW-1:0] SNZ_LAST   = SW'(SNOOZE_S - 1);
    localparam logic [UW-1:0] USED_LIMIT = UW'(MAX_SNOOZE);

    alarm_state_t  state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic [UW-1:0] snooze_used_q, snooze_used_d;
    logic          alarm_q;
    logic          match;

    blink_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_blink_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .sec_tick (sec_tick),
        .blink    (blink)
    );

    // Out-of-range alarm fields can never equal a valid current time.
    assign match = sec_tick && alarm_en && (cur_hour == alm_hour) &&
                   (cur_min == alm_min) && (cur_sec == '0);

    always_comb begin
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        snooze_used_d = snooze_used_q;
        unique case (state_q)
            IDLE: begin
                if (match) begin
                    state_d       = RINGING;
                    ring_cnt_d    = '0;
                    snooze_used_d = '0;
                end
            end
            RINGING: begin
                // Dismiss outranks snooze when both arrive together.
                if (!alarm_en || dismiss) begin
                    state_d = IDLE;
                end else if (snooze && (snooze_used_q < USED_LIMIT)) begin
                    state_d       = SNOOZING;
                    snz_cnt_d     = SNZ_LAST;
                    snooze_used_d = snooze_used_q + 1'b1;
                end else if (sec_tick) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 1'b1;
                    end
                end
            end
            SNOOZING: begin
                if (!alarm_en || dismiss) begin
                    state_d = IDLE;
                end else if (sec_tick) begin
                    if (snz_cnt_q == '0) begin
                        // snooze_used is kept so the per-event limit holds.
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            snooze_used_q <= '0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snooze_used_q <= snooze_used_d;
            alarm_q       <= (state_d == RINGING);
        end
    end

    assign alarm = alarm_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with small parameters:
// CLK_HZ=10, SNOOZE_S=3, RING_TIMEOUT_S=4, MAX_SNOOZE=1, sec_tick every 10 cycles.
module tb_alarm_controller;

    logic       clk;
    logic       rst_n;
    logic       sec_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic       alarm_en;
    logic       snooze;
    logic       dismiss;
    logic       blink;
    logic       alarm;

    int n_cmp = 0;
    int n_err = 0;

    alarm_controller #(
        .CLK_HZ         (10),
        .SNOOZE_S       (3),
        .RING_TIMEOUT_S (4),
        .MAX_SNOOZE     (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sec_tick (sec_tick),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .alm_hour (alm_hour),
        .alm_min  (alm_min),
        .alarm_en (alarm_en),
        .snooze   (snooze),
        .dismiss  (dismiss),
        .blink    (blink),
        .alarm    (alarm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    // Nine quiet cycles then a tick: keeps ticks 10 cycles apart.
    task automatic second();
        idle(9);
        tick();
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
    endtask

    task automatic pulse_dismiss();
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        sec_tick = 1'b0;
        cur_hour = 5'd0;
        cur_min  = 6'd0;
        cur_sec  = 6'd0;
        alm_hour = 5'd7;
        alm_min  = 6'd30;
        alarm_en = 1'b0;
        snooze   = 1'b0;
        dismiss  = 1'b0;

        #2;
        check("reset_alarm", alarm, 1'b0);
        check("reset_blink", blink, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(12);

        // Blink: high for cycles 1-5 after a tick, low for 6-10.
        for (int p = 0; p < 2; p++) begin
            tick();
            check("blink_c1", blink, 1'b1);
            for (int k = 2; k <= 10; k++) begin
                step();
                check($sformatf("blink_c%0d", k), blink, (k <= 5) ? 1'b1 : 1'b0);
            end
        end
        // No more ticks: blink parks low.
        for (int k = 0; k < 20; k++) begin
            step();
            if (k % 5 == 4) check("blink_stopped", blink, 1'b0);
        end

        // Ring trigger disabled by alarm_en=0.
        cur_hour = 5'd7;
        cur_min  = 6'd30;
        cur_sec  = 6'd0;
        tick();
        check("no_ring_disabled", alarm, 1'b0);
        idle(3);
        check("no_ring_disabled_later", alarm, 1'b0);

        // Ring trigger enabled.
        alarm_en = 1'b1;
        idle(5);
        check("pre_trigger", alarm, 1'b0);
        tick();
        check("trigger", alarm, 1'b1);
        cur_sec = 6'd1;

        // Timeout after 4 further ticks; a match mid-ring must not restart it,
        // and a match on the timeout tick must not re-trigger.
        second();
        check("ring_t1", alarm, 1'b1);
        cur_sec = 6'd0;
        second();
        check("ring_t2_match_ignored", alarm, 1'b1);
        cur_sec = 6'd1;
        second();
        check("ring_t3", alarm, 1'b1);
        idle(9);
        check("ring_pre_timeout", alarm, 1'b1);
        cur_sec = 6'd0;
        tick();
        check("timeout", alarm, 1'b0);
        cur_sec = 6'd1;
        idle(3);
        check("timeout_stays_idle", alarm, 1'b0);

        // Snooze, re-ring after 3 ticks, second snooze ignored, then dismiss.
        idle(5);
        cur_sec = 6'd0;
        tick();
        check("snz_trigger", alarm, 1'b1);
        cur_sec = 6'd1;
        idle(2);
        pulse_snooze();
        check("snooze_drop", alarm, 1'b0);
        second();
        check("snooze_t1", alarm, 1'b0);
        second();
        check("snooze_t2", alarm, 1'b0);
        second();
        check("snooze_rering", alarm, 1'b1);
        idle(2);
        pulse_snooze();
        check("snooze_limit", alarm, 1'b1);
        idle(3);
        check("snooze_limit_later", alarm, 1'b1);
        pulse_dismiss();
        check("dismiss", alarm, 1'b0);

        // Snooze and dismiss together: dismiss wins, no re-ring.
        idle(5);
        cur_sec = 6'd0;
        tick();
        check("prio_trigger", alarm, 1'b1);
        cur_sec = 6'd1;
        idle(2);
        snooze  = 1'b1;
        dismiss = 1'b1;
        step();
        snooze  = 1'b0;
        dismiss = 1'b0;
        check("prio_drop", alarm, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            second();
            check($sformatf("prio_no_rering_t%0d", t), alarm, 1'b0);
        end

        // Disarm during snooze returns to idle.
        cur_sec = 6'd0;
        tick();
        check("disarm_trigger", alarm, 1'b1);
        cur_sec = 6'd1;
        idle(2);
        pulse_snooze();
        check("disarm_snooze", alarm, 1'b0);
        second();
        alarm_en = 1'b0;
        step();
        alarm_en = 1'b1;
        for (int t = 2; t <= 4; t++) begin
            second();
            check($sformatf("disarm_no_rering_t%0d", t), alarm, 1'b0);
        end

        // Asynchronous reset mid-ring.
        cur_sec = 6'd0;
        tick();
        check("rst_trigger", alarm, 1'b1);
        cur_sec = 6'd1;
        idle(2);
        check("rst_pre_blink", blink, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_alarm", alarm, 1'b0);
        check("rst_async_blink", blink, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
        second();
        check("rst_no_ring_t1", alarm, 1'b0);
        second();
        check("rst_no_ring_t2", alarm, 1'b0);
        cur_sec = 6'd0;
        second();
        check("rst_next_match", alarm, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
